set_assoc_cache: RTL and testbench
==================================

Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, single-word-line cache; next generation of the direct-mapped L1/L2 models.
- Adds configurable sets/ways/widths, age-based LRU replacement, selectable write-through (no-allocate) or write-back (write-allocate) policy, and valid/ready handshakes on both sides.
- Sits between a CPU-side requester and a next-level memory or cache; instances chain to build L1/L2 hierarchies.
- Saturating hit/miss statistics counters.

Parameters:
- ADDR_W, 8: word address width.
- DATA_W, 32: word width.
- SETS, 4: number of sets; power of 2, ≥2; INDEX_W = clog2(SETS).
- WAYS, 2: associativity; power of 2, ≥1; AGE_W = max(1, clog2(WAYS)).
- WRITE_BACK, 0: 0 = write-through, no-write-allocate; 1 = write-back, write-allocate.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- cpu_req_valid  in  1  request valid
- cpu_req_ready  out  1  request accepted when valid&&ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_resp_valid
- cpu_hit  out  1  lookup result, valid with cpu_resp_valid
- mem_req_valid  out  1  next-level request
- mem_req_ready  in  1  next level accepts request
- mem_we  out  1  next-level write
- mem_addr  out  ADDR_W  next-level address
- mem_wdata  out  DATA_W  next-level write data
- mem_resp_valid  in  1  next level done; mem_rdata valid for reads
- mem_rdata  in  DATA_W  fill data
- clr_stats  in  1  synchronous clear of counters
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset (any state, including mid-transaction):
  - FSM returns to IDLE; all valid, dirty and age bits cleared; counters cleared.
  - cpu_resp_valid, cpu_hit, mem_req_valid, mem_we drop to 0 at the next edge.
  - cpu_rdata and mem_addr/mem_wdata reset to 0.
  - Data array contents are not reset.
  - cpu_req_ready = (state==IDLE) && rst_n.
- Address split: index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W].
- FSM states: IDLE, LOOKUP, WRBACK, FILL, WTHRU, RESP.
  - IDLE: ready=1; on accept, register we/addr/wdata and go to LOOKUP. Exactly one request in flight.
  - LOOKUP: tag compare on all ways of the set; hit = valid && tag match. Increment hit_cnt or miss_cnt.
  - Read hit: go to RESP with the way's data.
  - Read miss: select victim. If WRITE_BACK and victim dirty, go to WRBACK, else go to FILL.
  - Write hit, WT: update word, go to WTHRU.
  - Write hit, WB: update word, set dirty, go to RESP.
  - Write miss, WT: no allocate, go to WTHRU.
  - Write miss, WB: if victim dirty, go to WRBACK; else install word/tag, valid=1, dirty=1, go to RESP.
  - WRBACK: write victim tag:index / victim data to memory. On mem_resp_valid, go to FILL (read) or install the write (write miss) and go to RESP.
  - FILL: read the request address. On mem_resp_valid, install mem_rdata, valid=1, dirty=0, go to RESP with that data.
  - WTHRU: write the request address / wdata. On mem_resp_valid, go to RESP.
  - RESP: cpu_resp_valid=1 for exactly one cycle with cpu_hit = LOOKUP result, then IDLE.
- Memory handshake, each mem state:
  - mem_req_valid asserted with stable mem_we/addr/wdata until the mem_req_ready cycle, then deasserted.
  - Then wait for mem_resp_valid. It is ignored before acceptance; no timeout.
- Latency:
  - Read hit, or WB write hit: accept at cycle T, cpu_resp_valid at T+2, next accept at T+3 earliest.
  - A miss adds memory latency. No memory traffic on a hit except in WT writes.
- Victim selection: lowest-index invalid way; else the way with maximum age.
- Age update: on every hit or install, touched way's age = 0; ways with age < old age increment. Ages stay a permutation of 0..WAYS-1.
- WAYS=1 degenerates to direct-mapped, age logic constant.
- Counters:
  - Saturate at all-ones.
  - clr_stats wins over a same-cycle increment.
  - A WB write miss counts once as a miss.

Decomposition:
- Package cache_pkg: FSM state enum; WT/WB policy constants; clog2-based width helpers (INDEX_W, AGE_W); tag/valid/dirty line-meta typedef.
- Sub-module cache_lru: per-set age array. Inputs are set index, touch valid, and touched way; outputs are victim way and the invalid-way priority pick. Instantiated once.

Test Plan:
1. Defaults: cold read 0x20, memory returns 0xABCDEF → mem read addr 0x20; cpu_rdata 0xABCDEF, cpu_hit=0, miss_cnt=1. Reread 0x20 → hit, no mem_req_valid, response at T+2, hit_cnt=1.
2. LRU: reads 0x20, 0x24, 0x20, 0x28, 0x20 (all set 0) → last read hits (0x24 evicted); then read 0x24 → miss, fill from memory.
3. WT: write 0x12345 to cached 0x20 → mem write 0x20/0x12345; read 0x20 hits 0x12345. Write miss to 0x2C → mem write, no allocate; read 0x2C then misses.
4. WRITE_BACK=1: writes 0x20=0x1, 0x24=0x2 → no mem traffic. Write 0x28 → mem write 0x20/0x1 only. Read 0x20 → mem write 0x24/0x2, then mem read 0x20.
5. mem_req_ready held low 5 cycles during FILL → mem_req_valid/addr stable throughout, cpu_req_ready=0, no cpu_resp_valid.
6. rst_n low one cycle mid-FILL → mem_req_valid=0 next edge; read 0x20 afterwards misses; counters 0. Separately, CNT_W=2 with 5 hits → hit_cnt=3; clr_stats with a hit → 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache.
//   state_t      : controller FSM states
//   POLICY_*     : values accepted by the WRITE_BACK parameter
//   index_w/age_w: derived field widths
//   line_meta_t  : per-line tag/valid/dirty record (tag zero-extended to TAG_MAX_W)
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRBACK,
        ST_FILL,
        ST_WTHRU,
        ST_RESP
    } state_t;

    localparam int POLICY_WT = 0;
    localparam int POLICY_WB = 1;

    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_meta_t;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int age_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set age tracking for LRU replacement.
//   clk, rst_n  : clock, synchronous active-low reset
//   set_idx     : set being looked up / touched
//   valid_vec   : valid bits of that set's ways
//   touch       : touched way becomes most recent this cycle
//   touch_way   : way being touched
//   lru_way     : way with the maximum age in set_idx
//   inv_found   : set_idx has at least one invalid way
//   inv_way     : lowest-index invalid way
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS    = 4,
    parameter int WAYS    = 2,
    parameter int INDEX_W = 2,
    parameter int AGE_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic [WAYS-1:0]    valid_vec,
    input  logic               touch,
    input  logic [AGE_W-1:0]   touch_way,
    output logic [AGE_W-1:0]   lru_way,
    output logic               inv_found,
    output logic [AGE_W-1:0]   inv_way
);

    logic [AGE_W-1:0] age [SETS][WAYS];
    logic [AGE_W-1:0] touch_age;
    logic [AGE_W-1:0] max_age;

    assign touch_age = age[set_idx][touch_way];

    always_comb begin
        lru_way = '0;
        max_age = age[set_idx][0];
        for (int unsigned w = 1; w < WAYS; w++) begin
            if (age[set_idx][w] > max_age) begin
                max_age = age[set_idx][w];
                lru_way = AGE_W'(w);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_vec[w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
        end
    end

    // Ages are seeded with the identity permutation so that the
    // "ages are a permutation of 0..WAYS-1" invariant holds from reset;
    // with all-zero ages every touch would leave the set unordered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++)
                for (int unsigned w = 0; w < WAYS; w++)
                    age[s][w] <= AGE_W'(w);
        end else if (touch) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way)
                    age[set_idx][w] <= '0;
                else if (age[set_idx][w] < touch_age)
                    age[set_idx][w] <= age[set_idx][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative single-word-line cache with LRU replacement,
// write-through/no-allocate or write-back/write-allocate policy and
// saturating hit/miss counters.
//   clk, rst_n          : clock, synchronous active-low reset
//   cpu_req_*, cpu_we,
//   cpu_addr, cpu_wdata : CPU request (valid/ready)
//   cpu_resp_valid,
//   cpu_rdata, cpu_hit  : one-cycle completion pulse with data / hit flag
//   mem_req_*, mem_we,
//   mem_addr, mem_wdata : next-level request (valid/ready)
//   mem_resp_valid,
//   mem_rdata           : next-level completion / fill data
//   clr_stats           : clear hit_cnt / miss_cnt
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int SETS       = 4,
    parameter int WAYS       = 2,
    parameter int WRITE_BACK = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int INDEX_W = index_w(SETS);
    localparam int AGE_W   = age_w(WAYS);
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam bit WB      = (WRITE_BACK == POLICY_WB);

    state_t state, next_state;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              hit_r;
    logic [AGE_W-1:0]  victim_r;
    logic              mem_acc;

    line_meta_t        meta [SETS][WAYS];
    logic [DATA_W-1:0] data [SETS][WAYS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAYS-1:0]    valid_vec;
    logic               hit;
    logic [AGE_W-1:0]   hit_way;
    logic [AGE_W-1:0]   lru_way, inv_way, victim;
    logic               inv_found, victim_dirty, mem_done;
    logic               touch;
    logic [AGE_W-1:0]   touch_way;

    assign idx = req_addr[INDEX_W-1:0];
    assign tag = req_addr[ADDR_W-1:INDEX_W];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        valid_vec = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            valid_vec[w] = meta[idx][w].valid;
            if (meta[idx][w].valid && meta[idx][w].tag == TAG_MAX_W'(tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    cache_lru #(
        .SETS    (SETS),
        .WAYS    (WAYS),
        .INDEX_W (INDEX_W),
        .AGE_W   (AGE_W)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_idx   (idx),
        .valid_vec (valid_vec),
        .touch     (touch),
        .touch_way (touch_way),
        .lru_way   (lru_way),
        .inv_found (inv_found),
        .inv_way   (inv_way)
    );

    assign victim       = inv_found ? inv_way : lru_way;
    assign victim_dirty = WB && meta[idx][victim].valid && meta[idx][victim].dirty;
    // A response is only meaningful once our request has been accepted.
    assign mem_done     = mem_acc && mem_resp_valid;

    always_comb begin
        touch     = 1'b0;
        touch_way = victim_r;
        case (state)
            ST_LOOKUP: begin
                if (hit) begin
                    touch     = 1'b1;
                    touch_way = hit_way;
                end else if (req_we && WB && !victim_dirty) begin
                    touch     = 1'b1;
                    touch_way = victim;
                end
            end
            ST_WRBACK: touch = mem_done && req_we;
            ST_FILL:   touch = mem_done;
            default:   ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (cpu_req_valid) next_state = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit)
                    next_state = (req_we && !WB) ? ST_WTHRU : ST_RESP;
                else if (req_we)
                    next_state = !WB ? ST_WTHRU : (victim_dirty ? ST_WRBACK : ST_RESP);
                else
                    next_state = victim_dirty ? ST_WRBACK : ST_FILL;
            end
            ST_WRBACK: if (mem_done) next_state = req_we ? ST_RESP : ST_FILL;
            ST_FILL,
            ST_WTHRU:  if (mem_done) next_state = ST_RESP;
            ST_RESP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    assign cpu_req_ready  = (state == ST_IDLE) && rst_n;
    assign cpu_resp_valid = (state == ST_RESP);
    assign cpu_hit        = (state == ST_RESP) && hit_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_we        <= 1'b0;
            req_addr      <= '0;
            req_wdata     <= '0;
            hit_r         <= 1'b0;
            victim_r      <= '0;
            mem_acc       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_rdata     <= '0;
            for (int unsigned s = 0; s < SETS; s++)
                for (int unsigned w = 0; w < WAYS; w++)
                    meta[s][w] <= '0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                mem_req_valid <= 1'b0;
                mem_acc       <= 1'b1;
            end
            if (mem_done) mem_acc <= 1'b0;

            case (state)
                ST_IDLE: if (cpu_req_valid) begin
                    req_we    <= cpu_we;
                    req_addr  <= cpu_addr;
                    req_wdata <= cpu_wdata;
                end
                ST_LOOKUP: begin
                    hit_r    <= hit;
                    victim_r <= victim;
                    if (hit && !req_we) cpu_rdata <= data[idx][hit_way];
                    if (hit && req_we && WB) meta[idx][hit_way].dirty <= 1'b1;
                    case (next_state)
                        ST_WRBACK: begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= {meta[idx][victim].tag[TAG_W-1:0], idx};
                            mem_wdata     <= data[idx][victim];
                        end
                        ST_FILL: begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b0;
                            mem_addr      <= req_addr;
                        end
                        ST_WTHRU: begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= req_addr;
                            mem_wdata     <= req_wdata;
                        end
                        default: ;
                    endcase
                    if (!hit && req_we && WB && !victim_dirty)
                        meta[idx][victim] <= line_meta_t'{valid: 1'b1, dirty: 1'b1,
                                                          tag: TAG_MAX_W'(tag)};
                end
                ST_WRBACK: if (mem_done) begin
                    if (req_we) begin
                        meta[idx][victim_r] <= line_meta_t'{valid: 1'b1, dirty: 1'b1,
                                                            tag: TAG_MAX_W'(tag)};
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= req_addr;
                    end
                end
                ST_FILL: if (mem_done) begin
                    meta[idx][victim_r] <= line_meta_t'{valid: 1'b1, dirty: 1'b0,
                                                        tag: TAG_MAX_W'(tag)};
                    cpu_rdata           <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Data array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_LOOKUP && req_we) begin
                if (hit)
                    data[idx][hit_way] <= req_wdata;
                else if (WB && !victim_dirty)
                    data[idx][victim] <= req_wdata;
            end
            if (state == ST_WRBACK && mem_done && req_we) data[idx][victim_r] <= req_wdata;
            if (state == ST_FILL && mem_done)             data[idx][victim_r] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit && hit_cnt != '1)    hit_cnt  <= hit_cnt + 1'b1;
            if (!hit && miss_cnt != '1)  miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid, cpu_we, clr_stats;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_rdata;
    int          sel;

    logic        d_ready [3], d_resp [3], d_hit [3], d_mreq [3], d_mwe [3];
    logic [7:0]  d_maddr [3];
    logic [31:0] d_rdata [3], d_mwdata [3];
    logic [15:0] d_hc [3], d_mc [3];
    logic [1:0]  hc2, mc2;

    logic        r_ready, r_resp, r_hit, r_mreq, r_mwe;
    logic [7:0]  r_maddr;
    logic [31:0] r_rdata, r_mwdata;
    logic [15:0] r_hc, r_mc;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem_arr [256];
    logic        q_we [$];
    logic [7:0]  q_addr [$];
    logic [31:0] q_wdata [$];
    int          stall_cnt = 0;

    always #5 clk = ~clk;

    assign d_hc[2] = {14'b0, hc2};
    assign d_mc[2] = {14'b0, mc2};

    always_comb begin
        r_ready  = d_ready[sel];
        r_resp   = d_resp[sel];
        r_hit    = d_hit[sel];
        r_mreq   = d_mreq[sel];
        r_mwe    = d_mwe[sel];
        r_maddr  = d_maddr[sel];
        r_rdata  = d_rdata[sel];
        r_mwdata = d_mwdata[sel];
        r_hc     = d_hc[sel];
        r_mc     = d_mc[sel];
    end

    set_assoc_cache u_wt (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid && sel == 0), .cpu_req_ready(d_ready[0]),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(d_resp[0]), .cpu_rdata(d_rdata[0]), .cpu_hit(d_hit[0]),
        .mem_req_valid(d_mreq[0]), .mem_req_ready(mem_req_ready && sel == 0),
        .mem_we(d_mwe[0]), .mem_addr(d_maddr[0]), .mem_wdata(d_mwdata[0]),
        .mem_resp_valid(mem_resp_valid && sel == 0), .mem_rdata(mem_rdata),
        .clr_stats(clr_stats && sel == 0), .hit_cnt(d_hc[0]), .miss_cnt(d_mc[0])
    );

    set_assoc_cache #(.WRITE_BACK(1)) u_wb (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid && sel == 1), .cpu_req_ready(d_ready[1]),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(d_resp[1]), .cpu_rdata(d_rdata[1]), .cpu_hit(d_hit[1]),
        .mem_req_valid(d_mreq[1]), .mem_req_ready(mem_req_ready && sel == 1),
        .mem_we(d_mwe[1]), .mem_addr(d_maddr[1]), .mem_wdata(d_mwdata[1]),
        .mem_resp_valid(mem_resp_valid && sel == 1), .mem_rdata(mem_rdata),
        .clr_stats(clr_stats && sel == 1), .hit_cnt(d_hc[1]), .miss_cnt(d_mc[1])
    );

    set_assoc_cache #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid && sel == 2), .cpu_req_ready(d_ready[2]),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(d_resp[2]), .cpu_rdata(d_rdata[2]), .cpu_hit(d_hit[2]),
        .mem_req_valid(d_mreq[2]), .mem_req_ready(mem_req_ready && sel == 2),
        .mem_we(d_mwe[2]), .mem_addr(d_maddr[2]), .mem_wdata(d_mwdata[2]),
        .mem_resp_valid(mem_resp_valid && sel == 2), .mem_rdata(mem_rdata),
        .clr_stats(clr_stats && sel == 2), .hit_cnt(hc2), .miss_cnt(mc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Next-level memory: optional stall of ready, response one cycle after acceptance.
    initial begin
        logic resp_due;
        resp_due       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_due) begin
                mem_resp_valid = 1'b1;
                resp_due       = 1'b0;
            end
            mem_req_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            if (r_mreq && mem_req_ready) begin
                q_we.push_back(r_mwe);
                q_addr.push_back(r_maddr);
                q_wdata.push_back(r_mwdata);
                if (r_mwe) mem_arr[r_maddr] = r_mwdata;
                else       mem_rdata = mem_arr[r_maddr];
                resp_due = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_req(input logic we, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!r_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("req_ready_timeout", r_ready, 1);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_addr      = a;
        cpu_wdata     = d;
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic h, output int lat);
        lat = 1;
        while (!r_resp && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 300) check("resp_timeout", r_resp, 1);
        rd = r_rdata;
        h  = r_hit;
    endtask

    task automatic do_req(input logic we, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic h, output int lat);
        start_req(we, a, d);
        wait_resp(rd, h, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        h;
        int          lat, base;

        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hDEAD_0000 | 32'(i);
        mem_arr[8'h20] = 32'h00AB_CDEF;
        mem_arr[8'h24] = 32'h0000_2424;
        mem_arr[8'h30] = 32'h0000_3030;
        sel = 0; rst_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; clr_stats = 1'b0;

        do_reset();
        @(negedge clk);
        check("rst_ready", r_ready, 1);
        check("rst_resp", r_resp, 0);
        check("rst_mreq", r_mreq, 0);
        check("rst_rdata", r_rdata, 0);
        check("rst_hits", r_hc, 0);
        check("rst_miss", r_mc, 0);

        // Cold read then re-read
        do_req(0, 8'h20, 0, rd, h, lat);
        check("cold_maddr", q_addr[0], 8'h20);
        check("cold_mwe", q_we[0], 0);
        check("cold_rdata", rd, 32'hABCDEF);
        check("cold_hit", h, 0);
        check("cold_miss_cnt", r_mc, 1);
        base = q_addr.size();
        do_req(0, 8'h20, 0, rd, h, lat);
        check("reread_hit", h, 1);
        check("reread_rdata", rd, 32'hABCDEF);
        check("reread_lat", lat, 2);
        check("reread_no_mem", q_addr.size() - base, 0);
        check("reread_hit_cnt", r_hc, 1);

        // LRU: 0x24 evicted by 0x28 after 0x20 refreshed
        do_req(0, 8'h24, 0, rd, h, lat);
        check("lru_24_hit", h, 0);
        do_req(0, 8'h20, 0, rd, h, lat);
        check("lru_20_hit", h, 1);
        do_req(0, 8'h28, 0, rd, h, lat);
        check("lru_28_hit", h, 0);
        do_req(0, 8'h20, 0, rd, h, lat);
        check("lru_20_again_hit", h, 1);
        base = q_addr.size();
        do_req(0, 8'h24, 0, rd, h, lat);
        check("lru_24_refill_hit", h, 0);
        check("lru_24_refill_n", q_addr.size() - base, 1);
        check("lru_24_refill_addr", q_addr[base], 8'h24);
        check("lru_24_rdata", rd, 32'h2424);

        // Write-through
        base = q_addr.size();
        do_req(1, 8'h20, 32'h12345, rd, h, lat);
        check("wt_hit", h, 1);
        check("wt_mwe", q_we[base], 1);
        check("wt_maddr", q_addr[base], 8'h20);
        check("wt_mwdata", q_wdata[base], 32'h12345);
        base = q_addr.size();
        do_req(0, 8'h20, 0, rd, h, lat);
        check("wt_read_hit", h, 1);
        check("wt_read_rdata", rd, 32'h12345);
        check("wt_read_no_mem", q_addr.size() - base, 0);
        base = q_addr.size();
        do_req(1, 8'h2C, 32'h77, rd, h, lat);
        check("wt_miss_hit", h, 0);
        check("wt_miss_maddr", q_addr[base], 8'h2C);
        check("wt_miss_mwe", q_we[base], 1);
        do_req(0, 8'h2C, 0, rd, h, lat);
        check("wt_noalloc_hit", h, 0);
        check("wt_noalloc_rdata", rd, 32'h77);
        check("wt_hit_cnt", r_hc, 5);
        check("wt_miss_cnt", r_mc, 6);

        // Memory stall during FILL
        stall_cnt = 8;
        start_req(0, 8'h30, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_mreq", r_mreq, 1);
            check("stall_maddr", r_maddr, 8'h30);
            check("stall_ready", r_ready, 0);
            check("stall_resp", r_resp, 0);
        end
        wait_resp(rd, h, lat);
        check("stall_rdata", rd, 32'h3030);
        check("stall_hit", h, 0);

        // Reset mid-FILL
        stall_cnt = 20;
        start_req(0, 8'h34, 0);
        @(negedge clk);
        check("midfill_mreq", r_mreq, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mreq", r_mreq, 0);
        check("midrst_ready", r_ready, 0);
        check("midrst_hits", r_hc, 0);
        check("midrst_miss", r_mc, 0);
        check("midrst_rdata", r_rdata, 0);
        check("midrst_maddr", r_maddr, 0);
        rst_n = 1'b1;
        stall_cnt = 0;
        @(negedge clk);
        check("postrst_ready", r_ready, 1);
        do_req(0, 8'h20, 0, rd, h, lat);
        check("postrst_hit", h, 0);
        check("postrst_rdata", rd, 32'h12345);
        check("postrst_miss", r_mc, 1);
        check("postrst_hits", r_hc, 0);

        // Write-back / write-allocate
        sel = 1;
        do_reset();
        base = q_addr.size();
        do_req(1, 8'h20, 32'h1, rd, h, lat);
        check("wb_w20_hit", h, 0);
        check("wb_w20_lat", lat, 2);
        do_req(1, 8'h24, 32'h2, rd, h, lat);
        check("wb_w24_hit", h, 0);
        check("wb_no_mem", q_addr.size() - base, 0);
        do_req(1, 8'h28, 32'h3, rd, h, lat);
        check("wb_w28_n", q_addr.size() - base, 1);
        check("wb_w28_mwe", q_we[base], 1);
        check("wb_w28_maddr", q_addr[base], 8'h20);
        check("wb_w28_mwdata", q_wdata[base], 32'h1);
        do_req(0, 8'h20, 0, rd, h, lat);
        check("wb_r20_n", q_addr.size() - base, 3);
        check("wb_r20_ev_mwe", q_we[base+1], 1);
        check("wb_r20_ev_maddr", q_addr[base+1], 8'h24);
        check("wb_r20_ev_mwdata", q_wdata[base+1], 32'h2);
        check("wb_r20_fill_mwe", q_we[base+2], 0);
        check("wb_r20_fill_maddr", q_addr[base+2], 8'h20);
        check("wb_r20_rdata", rd, 32'h1);
        check("wb_r20_hit", h, 0);
        base = q_addr.size();
        do_req(1, 8'h20, 32'h5, rd, h, lat);
        check("wb_whit_hit", h, 1);
        check("wb_whit_lat", lat, 2);
        check("wb_whit_no_mem", q_addr.size() - base, 0);
        check("wb_miss_cnt", r_mc, 4);
        check("wb_hit_cnt", r_hc, 1);

        // Counter saturation and clear priority
        sel = 2;
        do_reset();
        do_req(0, 8'h20, 0, rd, h, lat);
        for (int i = 0; i < 5; i++) do_req(0, 8'h20, 0, rd, h, lat);
        check("sat_hit_cnt", r_hc, 3);
        check("sat_miss_cnt", r_mc, 1);
        clr_stats = 1'b1;
        do_req(0, 8'h20, 0, rd, h, lat);
        clr_stats = 1'b0;
        check("clr_hit", h, 1);
        check("clr_hit_cnt", r_hc, 0);
        check("clr_miss_cnt", r_mc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
